// File: rtl/divider_iterative.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on operand magnitudes, sign-corrected when the result is captured.
module divider_iterative #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            startE,
    input  logic [1:0]      div_opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic [XLEN-1:0] result_divide,
    output logic            ready,
    output logic            div_use
);

    localparam int unsigned CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q;
    logic            is_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] rem_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] result_q;
    logic            ready_q;

    logic            signed_op;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] final_res;
    logic            last_step;

    // Operand decode at acceptance; the most-negative dividend negates to itself,
    // which is exactly its unsigned magnitude.
    always_comb begin
        signed_op   = ~div_opcode[0];
        neg_a       = signed_op & operand1[XLEN-1];
        neg_b       = signed_op & operand2[XLEN-1];
        abs_a       = neg_a ? ('0 - operand1) : operand1;
        abs_b       = neg_b ? ('0 - operand2) : operand2;
        div_zero    = (operand2 == '0);
        overflow    = signed_op
                    && (operand1 == {1'b1, {(XLEN-1){1'b0}}})
                    && (operand2 == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = div_opcode[1] ? operand1 : '1;
        end else if (overflow) begin
            special_res = div_opcode[1] ? '0 : operand1;
        end
    end

    // One restoring step; the running remainder always stays below the divisor,
    // so the difference fits back into XLEN bits.
    always_comb begin
        shifted   = {rem_q, quo_q[XLEN-1]};
        ge        = (shifted >= {1'b0, dvs_q});
        rem_d     = ge ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];
        quo_d     = {quo_q[XLEN-2:0], ge};
        last_step = (cnt_q == CW'(STEPS - 1));
        if (is_rem_q) begin
            final_res = neg_rem_q ? ('0 - rem_d) : rem_d;
        end else begin
            final_res = neg_quo_q ? ('0 - quo_d) : quo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (startE) begin
                        is_rem_q  <= div_opcode[1];
                        neg_quo_q <= neg_a ^ neg_b;
                        neg_rem_q <= neg_a;
                        quo_q     <= abs_a;
                        dvs_q     <= abs_b;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        if (div_zero || overflow) begin
                            result_q <= special_res;
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        result_q <= final_res;
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result_divide = result_q;
    assign ready         = ready_q;
    assign div_use       = ((state_q == IDLE) && startE) || (state_q == CALC);

endmodule

// File: doc/divider_iterative.md
Name: divider_iterative

Overview:
Sequential radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It replaces the combinational divider_32bit in the execute stage and answers the same start/ready handshake that InstMcheck already drives for multiplier_iterative. It takes operands and div_opcode from InstMcheck and returns result_divide with a ready pulse. It raises div_use so the hazard logic holds fetch, decode and execute while a division is in progress.

Parameters:
XLEN, 32, operand and result width
STEPS, 32, iterations per division; must equal XLEN

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low
startE  input  1  execute-stage instruction is an M-extension divide; held high while the pipeline is stalled
div_opcode  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
operand1  input  XLEN  dividend (rs1)
operand2  input  XLEN  divisor (rs2)
result_divide  output  XLEN  quotient or remainder; held until the next accepted start
ready  output  1  one-cycle pulse: result_divide is valid
div_use  output  1  divider busy; stall request to the pipeline

Behaviour:
- Reset (rst=0 at a clk edge): state goes to IDLE; result_divide=0, ready=0, counter=0, internal registers cleared. Reset mid-division aborts the operation, and no ready is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - startE=1 at edge T accepts the operation. Latch opcode, sign flags, |dividend|, |divisor|, remainder register=0, counter=0.
  - Special cases bypass CALC and go straight to DONE at T+1.
- Special cases:
  - Divisor=0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = operand1.
  - Signed overflow (DIV/REM, operand1=0x80000000, operand2=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- CALC, one step per cycle:
  - Shift {rem, quo} left by 1, bringing in the next dividend MSB.
  - If rem >= divisor (33-bit compare): subtract the divisor and set quotient bit 1.
  - The counter increments each step. After step STEPS (cycle T+32), go to DONE at T+33.
- Sign fix-up, applied when entering DONE:
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the dividend's sign.
  - Unsigned opcodes use raw values.
  - The most-negative dividend is handled through the 32-bit unsigned magnitude 0x80000000.
- DONE:
  - ready=1 for exactly one cycle and result_divide is valid; next state is IDLE.
  - startE is ignored in DONE.
- div_use (combinational) = (IDLE & startE) | CALC.
  - It is low in DONE so the pipeline advances on the ready cycle.
  - On the special-case path it is high only in cycle T.
- startE in CALC or DONE never restarts or corrupts an operation. Operand and opcode changes after acceptance are ignored.
- Latency:
  - Normal: ready at T+33, with 33 stall cycles.
  - Special cases: ready at T+1.
- result_divide changes only when entering DONE or on reset.
- Back-to-back divides: the second startE is accepted in IDLE at T+34 at the earliest.
- Integration in TopLevel:
  - The hazard unit ORs div_use with mul_use.
  - InstMcheck selects result_divide when ready is asserted for a divide opcode.

Test Plan:
- DIVU 100/7 accepted at T -> div_use high T..T+32, ready only at T+33, result 14. REMU with the same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE (-2) -> 0xFFFFFFFD.
- Divide by zero, operand1=0x12345678, operand2=0:
  - DIVU -> 0xFFFFFFFF at T+1; REMU -> 0x12345678 at T+1; div_use high only in cycle T.
- Overflow, 0x80000000 / 0xFFFFFFFF:
  - DIV -> 0x80000000 at T+1; REM -> 0.
  - DIVU 0x80000000 / 0xFFFFFFFF -> 0 at T+33.
- startE held high and operands changed during CALC -> result unchanged (DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF), exactly one ready pulse. Second divide accepted at T+34 completes correctly.
- rst=0 at T+10 of a division -> next cycle: IDLE, ready=0, div_use=0 (with startE=0), result_divide=0, and no ready pulse afterwards.
